// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch front-end definitions: reset constants, fetch FSM encoding and the PC adder.
package instr_fetch_queue_pkg;

    localparam logic [15:0] DefaultNopInstr = 16'h0800;
    localparam logic [15:0] DefaultResetPc  = 16'h0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

    // 16-bit adder; the carry out is dropped so the fetch PC wraps silently.
    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Instruction memory request/response bus between the fetch queue and imem.
interface instr_fetch_queue_if;

    logic        req;
    logic [15:0] addr;
    logic        done;
    logic [15:0] data;

    modport master (
        output req,
        output addr,
        input  done,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output done,
        output data
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Circular buffer of {instr, pc_inc} entries with a synchronous flush and a
// combinational head read.
module instr_fetch_queue_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [31:0]            push_data,
    input  logic                   pop,
    output logic [31:0]            head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned      PtrW      = $clog2(DEPTH);
    localparam logic [PtrW:0]    FullCount = (PtrW + 1)'(DEPTH);

    logic [31:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    // Flush wins over any same-cycle push or pop.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the fetch PC, issues imem requests and queues fetched
// instructions for decode; a redirect from EX flushes everything in flight.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] RESET_PC  = DefaultResetPc,
    parameter logic [15:0] NOP_INSTR = DefaultNopInstr
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_queue_if.master    imem,
    input  logic                   redirect,
    input  logic [15:0]            redirect_pc,
    input  logic                   halt,
    input  logic                   de_ready,
    output logic                   de_valid,
    output logic [15:0]            de_instr,
    output logic [15:0]            de_pc_inc,
    output logic [$clog2(DEPTH):0] count
);

    fetch_state_e state_q, state_d;
    logic [15:0]  fetch_pc_q, fetch_pc_d;
    logic [15:0]  pc_inc;
    logic         req;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [31:0]  head_data;

    assign pc_inc = add16(fetch_pc_q, 16'd2);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req        = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            StIdle: begin
                // rst gates req so the port reads idle while reset is held.
                req  = rst & ~halt & ~redirect & ~full;
                push = req & imem.done;
                if (req && !imem.done) state_d = StWait;
            end
            StWait: begin
                req  = 1'b1;
                push = imem.done & ~redirect;
                if (imem.done) begin
                    state_d = StIdle;
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem.done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (push) begin
            fetch_pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign imem.req  = req;
    assign imem.addr = fetch_pc_q;

    assign pop = ~empty & de_ready & ~redirect;

    instr_fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({imem.data, pc_inc}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign de_valid  = ~empty;
    assign de_instr  = empty ? NOP_INSTR : head_data[31:16];
    assign de_pc_inc = empty ? 16'h0000 : head_data[15:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a per-cycle vector table plus hand-written
// sequences for multi-cycle imem latency, redirect and reset corner cases.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        de_ready = 1'b0;
    logic        de_valid;
    logic [15:0] de_instr;
    logic [15:0] de_pc_inc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    instr_fetch_queue_if imem ();

    instr_fetch_queue #(
        .DEPTH     (4),
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .de_ready    (de_ready),
        .de_valid    (de_valid),
        .de_instr    (de_instr),
        .de_pc_inc   (de_pc_inc),
        .count       (count)
    );

    always #5 clk = ~clk;

    // imem model: auto mode answers after lat extra cycles with data = addr + 0x1000.
    logic        auto_mem = 1'b1;
    int unsigned lat = 0;
    int unsigned lat_cnt = 0;
    logic        man_done = 1'b0;
    logic [15:0] man_data = 16'h0000;

    always @(posedge clk) begin
        if (!imem.req || imem.done) lat_cnt <= 0;
        else                        lat_cnt <= lat_cnt + 1;
    end

    always_comb begin
        imem.done = 1'b0;
        imem.data = 16'h0000;
        if (auto_mem) begin
            imem.done = imem.req && (lat_cnt == lat);
            imem.data = imem.addr + 16'h1000;
        end else begin
            imem.done = man_done;
            imem.data = man_data;
        end
    end

    typedef struct packed {
        logic        halt;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic [52:0] exp;
    } vec_t;

    localparam int NumVec = 17;
    vec_t vecs [NumVec];

    function automatic logic [52:0] obs();
        return {imem.req, imem.addr, de_valid, de_instr, de_pc_inc, count};
    endfunction

    function automatic vec_t mkv(input logic h, input logic r, input logic d,
                                 input logic [15:0] rpc, input logic rq,
                                 input logic [15:0] ad, input logic v,
                                 input logic [15:0] ins, input logic [15:0] pci,
                                 input logic [2:0] cnt);
        vec_t t;
        t.halt  = h;
        t.rdy   = r;
        t.redir = d;
        t.rpc   = rpc;
        t.exp   = {rq, ad, v, ins, pci, cnt};
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [52:0] ResetObs = {1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 3'd0};

    task automatic do_reset();
        rst = 1'b0;
        auto_mem = 1'b1;
        lat = 0;
        man_done = 1'b0;
        man_data = 16'h0000;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        de_ready = 1'b1;
        #1;
        check("reset_outputs", 64'(obs()), 64'(ResetObs));
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        //          halt  rdy   redir rpc       | req  addr      vld  instr     pc_inc    cnt
        vecs[0]  = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000, 3'd0);
        vecs[1]  = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h1000, 16'h0002, 3'd1);
        vecs[2]  = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h1002, 16'h0004, 3'd1);
        vecs[3]  = mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h1004, 16'h0006, 3'd1);
        vecs[4]  = mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h1004, 16'h0006, 3'd2);
        vecs[5]  = mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b1, 16'h1004, 16'h0006, 3'd3);
        vecs[6]  = mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h000C, 1'b1, 16'h1004, 16'h0006, 3'd4);
        vecs[7]  = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h000C, 1'b1, 16'h1004, 16'h0006, 3'd4);
        vecs[8]  = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h000C, 1'b1, 16'h1006, 16'h0008, 3'd3);
        vecs[9]  = mkv(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h000E, 1'b1, 16'h1008, 16'h000A, 3'd3);
        vecs[10] = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h000E, 1'b1, 16'h100A, 16'h000C, 3'd2);
        vecs[11] = mkv(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0010, 1'b1, 16'h100C, 16'h000E, 3'd2);
        vecs[12] = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0800, 16'h0000, 3'd0);
        vecs[13] = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h1040, 16'h0042, 3'd1);
        vecs[14] = mkv(1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0044, 1'b1, 16'h1042, 16'h0044, 3'd1);
        vecs[15] = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h0800, 16'h0000, 3'd0);
        vecs[16] = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0FFE, 16'h0000, 3'd1);

        // Zero-wait streaming, backpressure to full, halt, redirect and PC wrap.
        do_reset();
        for (int i = 0; i < NumVec; i++) begin
            halt        = vecs[i].halt;
            de_ready    = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("vec%0d", i), 64'(obs()), 64'(vecs[i].exp));
            tick();
        end

        // Three-cycle imem: address held for three cycles, one instruction per three.
        do_reset();
        lat = 2;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("lat_hold%0d", k), 64'({imem.req, imem.addr}), 64'({1'b1, 16'h0000}));
            tick();
        end
        #1;
        check("lat_first", 64'({imem.req, imem.addr, de_valid, de_pc_inc}),
              64'({1'b1, 16'h0002, 1'b1, 16'h0002}));
        repeat (6) tick();
        check("lat_rate", 64'({imem.req, imem.addr}), 64'({1'b1, 16'h0006}));

        // Redirect while waiting: the late word is dropped.
        do_reset();
        auto_mem = 1'b0;
        #1;
        check("drop_first_req", 64'({imem.req, imem.addr}), 64'({1'b1, 16'h0000}));
        tick();
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        check("drop_wait_req", 64'({imem.req, imem.addr}), 64'({1'b1, 16'h0000}));
        tick();
        redirect = 1'b0;
        #1;
        check("drop_state", 64'({imem.req, de_valid, count}), 64'({1'b0, 1'b0, 3'd0}));
        tick();
        man_done = 1'b1;
        man_data = 16'hDEAD;
        #1;
        check("drop_late_done", 64'({imem.req, de_valid}), 64'({1'b0, 1'b0}));
        tick();
        man_done = 1'b0;
        #1;
        check("drop_refetch", 64'({imem.req, imem.addr, de_valid, count}),
              64'({1'b1, 16'h0040, 1'b0, 3'd0}));
        tick();
        man_done = 1'b1;
        man_data = 16'h1234;
        tick();
        man_done = 1'b0;
        #1;
        check("drop_new_data", 64'({de_valid, de_instr, de_pc_inc, count, imem.addr}),
              64'({1'b1, 16'h1234, 16'h0042, 3'd1, 16'h0042}));

        // Redirect coinciding with imem_done while three entries are queued.
        do_reset();
        auto_mem = 1'b0;
        de_ready = 1'b0;
        man_done = 1'b1;
        man_data = 16'h7000;
        repeat (3) tick();
        check("flush_pre", 64'({count, imem.addr}), 64'({3'd3, 16'h0006}));
        man_done = 1'b0;
        tick();
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        man_done = 1'b1;
        tick();
        redirect = 1'b0;
        man_done = 1'b0;
        #1;
        check("flush_post", 64'({count, imem.req, imem.addr, de_valid}),
              64'({3'd0, 1'b1, 16'h0080, 1'b0}));

        // Halt during an outstanding request, then reset in the middle of a wait.
        do_reset();
        auto_mem = 1'b0;
        de_ready = 1'b0;
        tick();
        halt = 1'b1;
        man_done = 1'b1;
        man_data = 16'h5555;
        #1;
        check("halt_wait_req", 64'(imem.req), 64'(1'b1));
        tick();
        man_done = 1'b0;
        #1;
        check("halt_after", 64'({imem.req, de_valid, de_instr, count}),
              64'({1'b0, 1'b1, 16'h5555, 3'd1}));
        tick();
        halt = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_wait", 64'(obs()), 64'(ResetObs));
        halt = 1'b1;
        man_done = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("late_done_ignored", 64'({imem.req, count, de_valid}),
              64'({1'b0, 3'd0, 1'b0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
